// File: rtl/pulse_cond_pkg.sv
// pulse_cond_pkg
// Shared definitions for the pulse conditioner array:
//   pc_state_e - per-channel press/repeat FSM states
//   clog2_f    - ceiling log2, used to size counters
//   max_f      - larger of two values
package pulse_cond_pkg;

    typedef enum logic [1:0] {
        ST  = 2'b00,  // released
        PRS = 2'b01,  // first pressed cycle
        HLD = 2'b10,  // held, waiting for the first repeat
        RPT = 2'b11   // auto-repeating
    } pc_state_e;

    function automatic int unsigned clog2_f(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(v)) r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int unsigned max_f(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_cond_channel.sv
// pulse_cond_channel
// One button channel: synchroniser chain, debouncer and press/repeat FSM.
// Ports:
//   Clk           - clock, rising edge
//   Resetn        - asynchronous active-low reset
//   raw           - raw asynchronous button level (1 = pressed)
//   press_pulse   - one-cycle pulse on press and on each auto-repeat
//   release_pulse - one-cycle pulse the cycle after the debounced level falls
//   level         - debounced level
module pulse_cond_channel
    import pulse_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned DEB_CYCLES    = 4,
    parameter int unsigned REPEAT_EN     = 1,
    parameter int unsigned REPEAT_DELAY  = 8,
    parameter int unsigned REPEAT_PERIOD = 4
) (
    input  logic Clk,
    input  logic Resetn,
    input  logic raw,
    output logic press_pulse,
    output logic release_pulse,
    output logic level
);

    localparam int unsigned DW = clog2_f(DEB_CYCLES + 1);
    localparam int unsigned HW = clog2_f(max_f(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [DW-1:0]          deb_cnt;
    logic [HW-1:0]          hold_cnt;
    pc_state_e              state;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Counter tracks the run of consecutive samples disagreeing with level.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            deb_cnt <= '0;
            level   <= 1'b0;
        end else if (synced == level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
            deb_cnt <= '0;
            level   <= ~level;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // hold_cnt counts cycles since the last pulse; in HLD it saturates at
    // REPEAT_DELAY-1 when repeat is disabled so it can never wrap.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state         <= ST;
            hold_cnt      <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (!level) begin
                // Release takes priority, so a repeat due on this edge is dropped.
                if (state != ST) release_pulse <= 1'b1;
                state    <= ST;
                hold_cnt <= '0;
            end else begin
                case (state)
                    ST: begin
                        state       <= PRS;
                        press_pulse <= 1'b1;
                        hold_cnt    <= '0;
                    end
                    PRS: begin
                        state    <= HLD;
                        hold_cnt <= HW'(1);
                    end
                    HLD: begin
                        if (hold_cnt == HW'(REPEAT_DELAY - 1)) begin
                            if (REPEAT_EN != 0) begin
                                state       <= RPT;
                                press_pulse <= 1'b1;
                                hold_cnt    <= '0;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    RPT: begin
                        if (hold_cnt == HW'(REPEAT_PERIOD - 1)) begin
                            press_pulse <= 1'b1;
                            hold_cnt    <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state    <= ST;
                        hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/pulse_cond_array.sv
// pulse_cond_array
// N independent button conditioners (sync, debounce, press/auto-repeat).
// Ports:
//   Clk       - sole clock, rising edge
//   Resetn    - asynchronous active-low reset
//   A         - raw asynchronous button levels, 1 = pressed
//   A_pulse   - one-cycle press pulse per channel, plus repeat pulses
//   A_release - one-cycle pulse per channel on accepted release
//   A_level   - debounced level per channel
module pulse_cond_array #(
    parameter int unsigned N             = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned DEB_CYCLES    = 4,
    parameter int unsigned REPEAT_EN     = 1,
    parameter int unsigned REPEAT_DELAY  = 8,
    parameter int unsigned REPEAT_PERIOD = 4
) (
    input  logic         Clk,
    input  logic         Resetn,
    input  logic [N-1:0] A,
    output logic [N-1:0] A_pulse,
    output logic [N-1:0] A_release,
    output logic [N-1:0] A_level
);

    for (genvar g = 0; g < N; g++) begin : g_ch
        pulse_cond_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DEB_CYCLES   (DEB_CYCLES),
            .REPEAT_EN    (REPEAT_EN),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .Clk          (Clk),
            .Resetn       (Resetn),
            .raw          (A[g]),
            .press_pulse  (A_pulse[g]),
            .release_pulse(A_release[g]),
            .level        (A_level[g])
        );
    end

endmodule

// File: tb/tb_pulse_cond_array.sv
// tb_pulse_cond_array
// Scoreboard bench for pulse_cond_array. Two instances share the same A:
// one with defaults and one with auto-repeat disabled. A history-based
// reference model predicts every output after each rising edge; a monitor
// compares on the falling edge.
module tb_pulse_cond_array;

    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int RD   = 8;
    localparam int RP   = 4;
    localparam int HMAX = 4096;

    logic         Clk;
    logic         Resetn;
    logic [N-1:0] A;
    logic [N-1:0] pul, rel, lvl;
    logic [N-1:0] nr_pul, nr_rel, nr_lvl;

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] pul;
        logic [N-1:0] rel;
        logic [N-1:0] pul_nr;
    } exp_t;

    exp_t         sb[$];
    int           checks;
    int           failures;

    // reference model state: edge index since reset release, history of A
    // samples and of the debounced level, start edge of the current press
    int           k;
    logic [N-1:0] a_hist  [0:HMAX-1];
    logic [N-1:0] lvl_hist[0:HMAX-1];
    int           press   [N];

    int unsigned  run     [N];
    logic [N-1:0] v;

    pulse_cond_array dut (
        .Clk      (Clk),
        .Resetn   (Resetn),
        .A        (A),
        .A_pulse  (pul),
        .A_release(rel),
        .A_level  (lvl)
    );

    pulse_cond_array #(.REPEAT_EN(0)) dut_nr (
        .Clk      (Clk),
        .Resetn   (Resetn),
        .A        (A),
        .A_pulse  (nr_pul),
        .A_release(nr_rel),
        .A_level  (nr_lvl)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] samp(input int j);
        if (j < 1) return '0;
        return a_hist[j];
    endfunction

    task automatic model_reset();
        k           = 0;
        lvl_hist[0] = '0;
        for (int i = 0; i < N; i++) press[i] = 0;
        sb.delete();
    endtask

    // Reference model: a level toggles once DEB consecutive synchronised
    // samples (A delayed by SYNC edges) all disagree with it. Pulses are
    // derived from the press start edge with plain arithmetic.
    always @(posedge Clk) begin
        if (Resetn) begin
            exp_t         e;
            logic [N-1:0] s;
            logic         cur, tog, obs, pobs;
            int           d;
            k = k + 1;
            a_hist[k] = A;
            e = '0;
            for (int i = 0; i < N; i++) begin
                cur = lvl_hist[k-1][i];
                tog = 1'b1;
                for (int j = 0; j < DEB; j++) begin
                    if (k - j < 1) tog = 1'b0;
                    else begin
                        s = samp(k - j - SYNC);
                        if (s[i] == cur) tog = 1'b0;
                    end
                end
                lvl_hist[k][i] = cur ^ tog;
                obs  = lvl_hist[k-1][i];
                pobs = (k >= 2) ? lvl_hist[k-2][i] : 1'b0;
                e.rel[i] = !obs && pobs;
                if (obs && !pobs) begin
                    press[i]    = k;
                    e.pul[i]    = 1'b1;
                    e.pul_nr[i] = 1'b1;
                end else if (obs) begin
                    d = k - press[i];
                    if (d >= RD && ((d - RD) % RP) == 0) e.pul[i] = 1'b1;
                end
            end
            e.lvl = lvl_hist[k];
            sb.push_back(e);
        end
    end

    always @(negedge Clk) begin
        if (Resetn) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty actual=0 required=1 at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("level",      lvl,    e.lvl);
                chk("pulse",      pul,    e.pul);
                chk("release",    rel,    e.rel);
                chk("nr_level",   nr_lvl, e.lvl);
                chk("nr_pulse",   nr_pul, e.pul_nr);
                chk("nr_release", nr_rel, e.rel);
            end
        end
    end

    task automatic drive(input logic [N-1:0] val, input int cyc);
        repeat (cyc) begin
            @(negedge Clk);
            A = val;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pulse"},      pul,    '0);
        chk({tag, "_release"},    rel,    '0);
        chk({tag, "_level"},      lvl,    '0);
        chk({tag, "_nr_pulse"},   nr_pul, '0);
        chk({tag, "_nr_release"}, nr_rel, '0);
        chk({tag, "_nr_level"},   nr_lvl, '0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Resetn   = 1'b0;
        A        = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_zero("reset");
        @(negedge Clk);
        #2 Resetn = 1'b1;

        // short glitch on ch0, then a clean press on ch1
        drive(4'b0001, 3);
        drive(4'b0000, 12);
        drive(4'b0010, 10);
        drive(4'b0000, 15);
        // long hold on ch2 for auto-repeat
        drive(4'b0100, 30);
        drive(4'b0000, 15);
        // ch3 and ch0 together while ch1 bounces
        drive(4'b1011, 1);
        drive(4'b1001, 2);
        drive(4'b1011, 1);
        drive(4'b1001, 1);
        drive(4'b1011, 2);
        drive(4'b1001, 13);
        drive(4'b0000, 15);
        // single long hold (one pulse only on the repeat-disabled instance)
        drive(4'b0001, 40);
        drive(4'b0000, 15);

        // asynchronous reset in the middle of repeating on ch2
        drive(4'b0100, 20);
        @(posedge Clk);
        #3 Resetn = 1'b0;
        #1 check_zero("midreset");
        model_reset();
        repeat (3) @(negedge Clk);
        #2 Resetn = 1'b1;
        drive(4'b0100, 20);
        drive(4'b0000, 15);

        // random holds and bounces on every channel
        v = A;
        for (int i = 0; i < N; i++) run[i] = $urandom_range(1, 6);
        repeat (1500) begin
            for (int i = 0; i < N; i++) begin
                if (run[i] == 0) begin
                    v[i]   = ~v[i];
                    run[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40)
                                                         : $urandom_range(1, 6);
                end else begin
                    run[i] = run[i] - 1;
                end
            end
            @(negedge Clk);
            A = v;
        end
        drive(4'b0000, 20);

        @(posedge Clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
